// File: rtl/blink_meter.sv
// Measures the half-period of an asynchronous square wave in clk cycles and
// hands each result to a consumer through a valid/ready hold register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no reference edge yet (after reset or a stall); the next edge
//         | only starts the count
// MEASURE | counting cycles since the last edge; each edge emits cnt
module blink_meter #(
    parameter int cnt_w   = 16,
    parameter int timeout = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [cnt_w-1:0] m_period,
    output logic             m_level,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    output logic             stalled
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [cnt_w-1:0] timeout_val = cnt_w'(timeout);
    localparam logic [cnt_w-1:0] cnt_one     = cnt_w'(1);

    state_t           state;
    state_t           state_nxt;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_nxt;
    logic             s1;
    logic             s2;
    logic             prev;
    logic             edge_det;
    logic             emit;
    logic             stall_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign edge_det = s2 ^ prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt saturates at timeout by falling back to IDLE, so it never wraps
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        stall_set = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    cnt_nxt   = cnt_one;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    emit    = 1'b1;
                    cnt_nxt = cnt_one;
                end else if (cnt == timeout_val) begin
                    state_nxt = IDLE;
                    stall_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + cnt_one;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stalled <= 1'b0;
        end else if (edge_det) begin
            stalled <= 1'b0;
        end else if (stall_set) begin
            stalled <= 1'b1;
        end
    end

    // A new result may replace the held one only when the held one leaves
    // in the same cycle; otherwise the new one is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_period <= '0;
            m_level  <= 1'b0;
            m_valid  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!m_valid || m_ready) begin
                    m_period <= cnt;
                    m_level  <= s2;
                    m_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_meter.sv
// Scoreboard bench for blink_meter: a cycle-level reference model predicts
// emitted measurements, overrun and stall; a monitor checks every cycle.
module tb_blink_meter;

    localparam int CW = 16;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          d = 1'b0;
    logic          m_ready = 1'b0;
    logic [CW-1:0] m_period;
    logic          m_level;
    logic          m_valid;
    logic          overrun;
    logic          stalled;

    int checks = 0;
    int errors = 0;

    blink_meter #(.cnt_w(CW), .timeout(TO)) dut (
        .clk(clk),
        .rst(rst),
        .d(d),
        .m_period(m_period),
        .m_level(m_level),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .overrun(overrun),
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, longint act, longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int   per;
        logic lev;
    } meas_t;

    meas_t exp_q[$];
    int    cap_t[$];
    logic  cap_lvl[$];
    int    t = 0;
    logic  lvl_m = 1'b0;
    bit    have_h = 0;
    int    last_h = 0;
    int    stall_at = -1;
    bit    mv = 0;
    bit    ovr_m = 0;
    bit    stall_m = 0;
    bit    check_en = 0;

    // An input change seen at clock t is acted upon at clock t+2; results
    // follow from the spacing between handled edges and the buffer rule.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cap_t.delete();
            cap_lvl.delete();
            lvl_m    = 1'b0;
            have_h   = 0;
            stall_at = -1;
            mv       = 0;
            ovr_m    = 0;
            stall_m  = 0;
        end else begin
            bit    emit;
            meas_t m;
            t++;
            emit  = 0;
            ovr_m = 0;
            m.per = 0;
            m.lev = 1'b0;
            if (cap_t.size() > 0 && cap_t[0] == t) begin
                void'(cap_t.pop_front());
                m.lev   = cap_lvl.pop_front();
                stall_m = 0;
                if (have_h && (t - last_h) <= TO) begin
                    emit  = 1;
                    m.per = t - last_h;
                end
                have_h   = 1;
                last_h   = t;
                stall_at = t + TO;
            end else if (t == stall_at) begin
                stall_m  = 1;
                have_h   = 0;
                stall_at = -1;
            end
            if (emit) begin
                if (!mv || m_ready) begin
                    exp_q.push_back(m);
                    mv = 1;
                end else begin
                    ovr_m = 1;
                end
            end else if (mv && m_ready) begin
                mv = 0;
            end
            if (d !== lvl_m) begin
                lvl_m = d;
                cap_t.push_back(t + 2);
                cap_lvl.push_back(d);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("m_valid", m_valid, mv);
            chk("overrun", overrun, ovr_m);
            chk("stalled", stalled, stall_m);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    meas_t e;
                    e = exp_q.pop_front();
                    chk("m_period", m_period, e.per);
                    chk("m_level", m_level, e.lev);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(int n, bit rnd_rdy);
        repeat (n) begin
            step();
            if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_t(int target);
        int guard = 0;
        while (t < target && guard < 200) begin
            step();
            guard++;
        end
        if (t < target) chk("wait_t_timeout", t, target);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_m_period"}, m_period, 0);
        chk({tag, "_m_level"}, m_level, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_stalled"}, stalled, 0);
    endtask

    initial begin
        int e_cap;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) step();
        rst = 1'b0;
        check_en = 1;

        // toggles every 3 cycles, always ready
        m_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            step();
            if (i % 3 == 0) d = ~d;
        end

        // toggles every 5 cycles, consumer stalls for 20 cycles
        for (int i = 0; i < 45; i++) begin
            step();
            if (i % 5 == 0) d = ~d;
            m_ready = (i >= 20);
        end
        idle_cycles(6, 0);

        // stall detection and recovery
        d = ~d;
        idle_cycles(4, 0);
        d = ~d;
        e_cap = t + 1;
        wait_t(e_cap + 2 + TO - 1);
        #2 chk("stalled_early", stalled, 0);
        step();
        #2 chk("stalled_on_time", stalled, 1);
        idle_cycles(3, 0);
        d = ~d;
        idle_cycles(5, 0);
        #2 chk("no_meas_after_stall", m_valid, 0);
        step();
        d = ~d;
        idle_cycles(8, 0);

        // latency from first capture to m_valid
        d = ~d;
        idle_cycles(4, 0);
        d = ~d;
        idle_cycles(4, 0);
        d = ~d;
        e_cap = t + 1;
        wait_t(e_cap + 1);
        #2 chk("latency_not_early", m_valid, 0);
        step();
        #2 chk("latency_on_time", m_valid, 1);
        idle_cycles(4, 0);

        // back-to-back transfer and new edge, toggles every 2 cycles
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i % 2 == 0) d = ~d;
        end
        idle_cycles(6, 0);

        // reset between clock edges while a measurement is held
        m_ready = 1'b0;
        d = ~d;
        idle_cycles(3, 0);
        d = ~d;
        idle_cycles(4, 0);
        #2 chk("held_before_reset", m_valid, 1);
        step();
        #4 rst = 1'b1;
        #1 check_all_zero("async_reset");
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        idle_cycles(2, 0);
        d = ~d;
        idle_cycles(5, 0);
        #2 chk("first_edge_after_reset", m_valid, 0);
        step();
        d = ~d;
        idle_cycles(6, 0);

        // randomized spacing and consumer readiness
        for (int k = 0; k < 60; k++) begin
            idle_cycles($urandom_range(1, TO + 3), 1);
            d = ~d;
        end

        m_ready = 1'b1;
        idle_cycles(20, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
